// File: rtl/stream_pattern_pkg.sv
// stream_pattern_pkg: shared types and constants for the stream pattern generator.
//   pattern_e  : pattern mode encoding (matches the 3-bit pattern port)
//   state_e    : generator FSM states
//   lfsr_taps  : Fibonacci LFSR tap masks for 32/64/128-bit data
//                (present only when PATTERN_LFSR_EN is defined)
//   lane_seed  : first beat of lane-counter mode (lane i holds i)
//   pattern_legal : which pattern codes start a burst in this build
// Build option: PATTERN_LFSR_EN enables mode 3 (LFSR).
package stream_pattern_pkg;

  typedef enum logic [2:0] {
    PAT_LANE  = 3'd0,
    PAT_COUNT = 3'd1,
    PAT_WALK1 = 3'd2,
    PAT_LFSR  = 3'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest DATA_W the constant helpers below can describe.
  localparam int MAX_W = 256;

`ifdef PATTERN_LFSR_EN
  // Tap masks: bit (t-1) set for tap position t.
  localparam logic [31:0]  LFSR_TAPS_32  = 32'h8020_0003;                             // 32,22,2,1
  localparam logic [63:0]  LFSR_TAPS_64  = 64'hD800_0000_0000_0000;                   // 64,63,61,60
  localparam logic [127:0] LFSR_TAPS_128 = 128'hA000_0014_0000_0000_0000_0000_0000_0000; // 128,126,101,99

  function automatic logic [MAX_W-1:0] lfsr_taps(input int width);
    logic [MAX_W-1:0] t;
    t = '0;
    case (width)
      32:      t = MAX_W'(LFSR_TAPS_32);
      64:      t = MAX_W'(LFSR_TAPS_64);
      128:     t = MAX_W'(LFSR_TAPS_128);
      default: t = '0;
    endcase
    return t;
  endfunction
`endif

  // Lane i = i (modulo the lane width), for data_w/lane_w lanes.
  function automatic logic [MAX_W-1:0] lane_seed(input int data_w, input int lane_w);
    logic [MAX_W-1:0] s;
    logic [MAX_W-1:0] m;
    s = '0;
    m = (MAX_W'(1) << lane_w) - MAX_W'(1);
    for (int i = 0; i < MAX_W; i++)
      if (i < data_w / lane_w) s = s | ((MAX_W'(i) & m) << (i * lane_w));
    return s;
  endfunction

  function automatic logic pattern_legal(input logic [2:0] p);
    logic ok;
    case (p)
      PAT_LANE, PAT_COUNT, PAT_WALK1: ok = 1'b1;
`ifdef PATTERN_LFSR_EN
      PAT_LFSR:                       ok = 1'b1;
`endif
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/stream_pattern_generator_pattern_next_value.sv
// pattern_next_value: combinational seed and successor for one beat.
//   mode : pattern mode (3 bits)
//   cur  : current beat value
//   seed : first beat for this mode
//   next : beat following cur for this mode
// Build option: PATTERN_LFSR_EN adds the mode-3 Fibonacci LFSR.
module pattern_next_value
  import stream_pattern_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LANE_W = 8
) (
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] next
);

  localparam int NUM_LANES = DATA_W / LANE_W;
  localparam logic [MAX_W-1:0] SEED_FULL = lane_seed(DATA_W, LANE_W);

  logic [DATA_W-1:0] lane_next;
  logic [DATA_W-1:0] lane_seed_v;

  assign lane_seed_v = SEED_FULL[DATA_W-1:0];

  // Each lane steps by the lane count; carries stay inside the lane.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_next[g*LANE_W +: LANE_W] = cur[g*LANE_W +: LANE_W] + LANE_W'(NUM_LANES);
  end

`ifdef PATTERN_LFSR_EN
  localparam logic [MAX_W-1:0] TAPS_FULL = lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] TAPS = TAPS_FULL[DATA_W-1:0];
  logic [DATA_W-1:0] lfsr_next;
  // Shift toward the MSB, feedback XOR of the tapped bits into bit 0.
  // All-ones seed keeps the register out of the stuck all-zeros state.
  assign lfsr_next = {cur[DATA_W-2:0], ^(cur & TAPS)};
`endif

  always_comb begin
    seed = '0;
    next = cur;
    case (pattern_e'(mode))
      PAT_LANE: begin
        seed = lane_seed_v;
        next = lane_next;
      end
      PAT_COUNT: begin
        seed = '0;
        next = cur + DATA_W'(1);
      end
      PAT_WALK1: begin
        seed = DATA_W'(1);
        next = {cur[DATA_W-2:0], cur[DATA_W-1]};
      end
`ifdef PATTERN_LFSR_EN
      PAT_LFSR: begin
        seed = '1;
        next = lfsr_next;
      end
`endif
      default: begin
        seed = '0;
        next = cur;
      end
    endcase
  end

endmodule

// File: rtl/stream_pattern_generator.sv
// stream_pattern_generator: burst/continuous test-pattern source on a
// valid/ready stream.
//   clk, reset        : clock, synchronous active-high reset
//   pattern           : mode, sampled on start (0 lane, 1 count, 2 walk-1, 3 LFSR)
//   start             : begin a burst (IDLE only)
//   enable_gener      : low holds off new beats
//   burst_len         : beats per burst, sampled on start; 0 = continuous
//   abort             : end the burst after the pending handshake
//   dataout/_valid/_ready : output stream
//   busy              : high while running
//   done              : one-cycle pulse at burst end
//   beat_count        : beats accepted, held until the next start
// Build option: PATTERN_LFSR_EN enables mode 3; otherwise 3 is reserved.
module stream_pattern_generator
  import stream_pattern_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        pattern,
  input  logic              start,
  input  logic              enable_gener,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              abort,
  output logic [DATA_W-1:0] dataout,
  output logic              dataout_valid,
  input  logic              dataout_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  beat_count
);

  state_e            state;
  pattern_e          mode_q;
  logic [CNT_W-1:0]  len_q;
  logic              abort_pend;

  logic [2:0]        mode_sel;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] next;
  logic              xfer;
  logic              last_beat;
  logic              stop_req;
  logic [CNT_W-1:0]  cnt_inc;

  // In IDLE the seed must follow the incoming pattern; afterwards the
  // latched mode drives the successor.
  assign mode_sel = (state == ST_IDLE) ? pattern : mode_q;

  pattern_next_value #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_next (
    .mode (mode_sel),
    .cur  (dataout),
    .seed (seed),
    .next (next)
  );

  assign xfer      = dataout_valid && dataout_ready;
  assign cnt_inc   = (beat_count == '1) ? beat_count : beat_count + CNT_W'(1);
  assign last_beat = (len_q != '0) && (beat_count + CNT_W'(1) == len_q);
  assign stop_req  = abort || abort_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      mode_q        <= PAT_LANE;
      len_q         <= '0;
      abort_pend    <= 1'b0;
      dataout       <= '0;
      dataout_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      beat_count    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && pattern_legal(pattern)) begin
            state         <= ST_RUN;
            mode_q        <= pattern_e'(pattern);
            len_q         <= burst_len;
            abort_pend    <= 1'b0;
            dataout       <= seed;
            dataout_valid <= enable_gener;
            beat_count    <= '0;
            busy          <= 1'b1;
          end
        end

        ST_RUN: begin
          if (xfer) begin
            dataout    <= next;
            beat_count <= cnt_inc;
            if (last_beat || stop_req) begin
              state         <= ST_DONE;
              dataout_valid <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              abort_pend    <= 1'b0;
            end else begin
              dataout_valid <= enable_gener;
            end
          end else if (dataout_valid) begin
            // Stalled: hold the beat; remember an abort until it drains.
            if (abort) abort_pend <= 1'b1;
          end else if (stop_req) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            abort_pend <= 1'b0;
          end else begin
            dataout_valid <= enable_gener;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pattern_generator.sv
module tb_stream_pattern_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  pattern;
  logic        start;
  logic        enable_gener;
  logic [31:0] burst_len;
  logic        abort;
  logic [63:0] dataout;
  logic        dataout_valid;
  logic        dataout_ready;
  logic        busy;
  logic        done;
  logic [31:0] beat_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_pattern_generator #(.DATA_W(64), .LANE_W(8), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .pattern       (pattern),
    .start         (start),
    .enable_gener  (enable_gener),
    .burst_len     (burst_len),
    .abort         (abort),
    .dataout       (dataout),
    .dataout_valid (dataout_valid),
    .dataout_ready (dataout_ready),
    .busy          (busy),
    .done          (done),
    .beat_count    (beat_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Beat k of a burst, straight from the pattern definitions.
  function automatic logic [63:0] exp_beat(input int mode, input int k);
    logic [63:0] v;
    v = '0;
    case (mode)
      0: for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(i + 8 * k);
      1: v = 64'(k);
      2: v = 64'd1 << (k % 64);
      default: begin
        v = '1;
        repeat (k) v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
      end
    endcase
    return v;
  endfunction

  function automatic logic roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // One burst with random ready/enable, optional abort once abort_at beats
  // have been accepted. Noise on start/pattern/burst_len while running must
  // be ignored.
  task automatic run_burst(input int mode, input int len, input int rdy_pct,
                           input int en_pct, input int abort_at);
    logic [63:0] held;
    logic        stalled, prev_valid, prev_en, fin;
    int          n, exp_final;
    n = 0; exp_final = -1; stalled = 0; prev_valid = 0; fin = 0; held = '0;
    @(negedge clk);
    pattern = 3'(mode); burst_len = len; start = 1'b1; abort = 1'b0;
    enable_gener = roll(en_pct); dataout_ready = 1'b0;
    prev_en = enable_gener;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("count_cleared", 64'(beat_count), 64'd0);
    check("first_valid_latency", 64'(dataout_valid), 64'(prev_en));
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done) begin
        fin = 1;
        check("final_beats", 64'(n), 64'(exp_final < 0 ? len : exp_final));
        check("done_count", 64'(beat_count), 64'(n));
        check("done_valid_low", 64'(dataout_valid), 64'd0);
        check("done_busy_low", 64'(busy), 64'd0);
        break;
      end
      if (stalled) begin
        check("stall_valid_held", 64'(dataout_valid), 64'd1);
        check("stall_data_held", dataout, held);
      end
      if (dataout_valid && !prev_valid)
        check("valid_rise_needs_enable", 64'(prev_en), 64'd1);
      // Inputs for the next edge.
      dataout_ready = roll(rdy_pct);
      enable_gener  = roll(en_pct);
      start         = roll(20);
      pattern       = 3'($urandom_range(7));
      burst_len     = $urandom_range(3);
      if (abort_at >= 0 && n >= abort_at && !abort) begin
        abort = 1'b1;
        exp_final = dataout_valid ? n + 1 : n;
        if (len != 0 && exp_final > len) exp_final = len;
      end
      prev_en = enable_gener;
      prev_valid = dataout_valid;
      if (dataout_valid && dataout_ready) begin
        check($sformatf("beat_m%0d_%0d", mode, n), dataout, exp_beat(mode, n));
        n++;
        stalled = 0;
      end else begin
        stalled = dataout_valid;
      end
      held = dataout;
    end
    start = 1'b0; abort = 1'b0;
    check("burst_finished", 64'(fin), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("count_holds", 64'(beat_count), 64'(n));
    check("idle_not_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; pattern = '0; start = 0; enable_gener = 0; burst_len = '0;
    abort = 0; dataout_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_dataout", dataout, 64'd0);
    check("rst_valid", 64'(dataout_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(beat_count), 64'd0);
    reset = 1'b0;

    // Directed bursts.
    run_burst(0, 3, 100, 100, -1);
    run_burst(2, 66, 100, 100, -1);     // walking one wraps MSB -> bit 0
    run_burst(1, 4, 50, 100, -1);       // backpressure
    run_burst(1, 0, 100, 60, 6);        // continuous, enable gaps, abort
    run_burst(1, 0, 30, 100, 3);        // abort likely while stalled
    run_burst(0, 5, 100, 100, 4);       // abort on the last beat: one done
    run_burst(2, 0, 100, 100, 0);       // immediate abort, pending beat
    run_burst(1, 0, 100, 0, 0);         // abort with valid never raised

    // Reserved patterns are ignored.
    begin
      int rsv[$];
      rsv = '{4, 5, 6, 7};
`ifndef PATTERN_LFSR_EN
      rsv.push_back(3);
`endif
      foreach (rsv[i]) begin
        @(negedge clk);
        pattern = 3'(rsv[i]); burst_len = 2; start = 1; enable_gener = 1;
        dataout_ready = 1;
        @(negedge clk);
        start = 0;
        check($sformatf("reserved_%0d_busy", rsv[i]), 64'(busy), 64'd0);
        check($sformatf("reserved_%0d_valid", rsv[i]), 64'(dataout_valid), 64'd0);
      end
    end

`ifdef PATTERN_LFSR_EN
    run_burst(3, 2, 100, 100, -1);
    run_burst(3, 20, 60, 80, -1);
`endif

    // Reset in the middle of an 8-beat burst.
    @(negedge clk);
    pattern = 3'd1; burst_len = 8; start = 1; enable_gener = 1; dataout_ready = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("pre_reset_beat1", dataout, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_dataout", dataout, 64'd0);
    check("midrst_valid", 64'(dataout_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_count", 64'(beat_count), 64'd0);
    @(negedge clk);
    check("midrst_no_done", 64'(done), 64'd0);
    run_burst(0, 3, 100, 100, -1);

    // Random bursts.
    for (int r = 0; r < 8; r++) begin
      int m, l, ab;
`ifdef PATTERN_LFSR_EN
      m = $urandom_range(3);
`else
      m = $urandom_range(2);
`endif
      l = $urandom_range(10);
      ab = (l == 0 || roll(40)) ? $urandom_range(8) : -1;
      run_burst(m, l, $urandom_range(100, 30), $urandom_range(100, 40), ab);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
